// File: rtl/antenna_phase_extractor_pkg.sv
// Shared radar definitions: binary-angle constants, CORDIC arctangent table
// and the phase extractor FSM states.
package antenna_phase_extractor_pkg;

    localparam logic [31:0] PI32      = 32'h8000_0000;
    localparam logic [31:0] HALF_PI32 = 32'h4000_0000;

    // Extra fractional bits carried through x/y and z so that truncation in
    // the shifted adds stays well below one output LSB.
    localparam int unsigned CORDIC_XY_GUARD = 8;
    localparam int unsigned CORDIC_Z_GUARD  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREROT,
        S_ITER,
        S_STORE,
        S_DONE
    } ape_state_e;

    function automatic logic [31:0] atan32(input int unsigned i);
        case (i)
            0:       atan32 = HALF_PI32 >> 1;
            1:       atan32 = 32'h12E4_051E;
            2:       atan32 = 32'h09FB_385B;
            3:       atan32 = 32'h0511_11D4;
            4:       atan32 = 32'h028B_0D43;
            5:       atan32 = 32'h0145_D7E1;
            6:       atan32 = 32'h00A2_F61E;
            7:       atan32 = 32'h0051_7C57;
            8:       atan32 = 32'h0028_BE53;
            9:       atan32 = 32'h0014_5F2F;
            10:      atan32 = 32'h000A_2F98;
            11:      atan32 = 32'h0005_17CC;
            12:      atan32 = 32'h0002_8BE6;
            13:      atan32 = 32'h0001_45F3;
            14:      atan32 = 32'h0000_A2FA;
            15:      atan32 = 32'h0000_517D;
            default: atan32 = '0;
        endcase
    endfunction

    // Round-to-nearest reduction of the table entry to a w-bit binary angle.
    function automatic logic [31:0] atan_scaled(input int unsigned i, input int unsigned w);
        logic [31:0] a;
        a = atan32(i);
        if (w >= 32)
            return a;
        return (a + (32'd1 << (31 - w))) >> (32 - w);
    endfunction

endpackage

// File: rtl/antenna_phase_extractor_cordic_vector_iter.sv
// Iterative vectoring CORDIC: pre-rotates into the right half-plane, then
// drives y to zero while accumulating the binary-angle phase in z.
module cordic_vector_iter
    import antenna_phase_extractor_pkg::*;
#(
    parameter int unsigned IQ_WIDTH     = 16,
    parameter int unsigned PHASE_WIDTH  = 16,
    parameter int unsigned CORDIC_ITERS = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic signed [IQ_WIDTH-1:0]    i_in,
    input  logic signed [IQ_WIDTH-1:0]    q_in,
    output logic                          done,
    output logic        [PHASE_WIDTH-1:0] phase
);

    localparam int unsigned DW = IQ_WIDTH + 2 + CORDIC_XY_GUARD;
    localparam int unsigned ZW = PHASE_WIDTH + CORDIC_Z_GUARD;
    localparam int unsigned CW = $clog2(CORDIC_ITERS) + 1;
    localparam logic [CW-1:0] LAST_ITER  = CW'(CORDIC_ITERS - 1);
    localparam logic [ZW-1:0] Z_PI       = ZW'(PI32 >> (32 - ZW));
    localparam logic [ZW-1:0] Z_HALF_LSB = ZW'(1) << (CORDIC_Z_GUARD - 1);

    logic signed [DW-1:0] x, y, i_ext, q_ext, x_sh, y_sh;
    logic        [ZW-1:0] z, atan_cur, z_rnd;
    logic        [CW-1:0] cnt;
    logic                 running;

    always_comb begin
        i_ext    = {{2{i_in[IQ_WIDTH-1]}}, i_in, {CORDIC_XY_GUARD{1'b0}}};
        q_ext    = {{2{q_in[IQ_WIDTH-1]}}, q_in, {CORDIC_XY_GUARD{1'b0}}};
        x_sh     = x >>> cnt;
        y_sh     = y >>> cnt;
        atan_cur = ZW'(atan_scaled(32'(cnt), ZW));
        z_rnd    = z + Z_HALF_LSB;
        phase    = z_rnd[ZW-1:CORDIC_Z_GUARD];
        done     = running && (cnt == LAST_ITER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            running <= 1'b0;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= '0;
            if (i_in[IQ_WIDTH-1]) begin
                x <= -i_ext;
                y <= -q_ext;
                z <= Z_PI;
            end else begin
                x <= i_ext;
                y <= q_ext;
                z <= '0;
            end
        end else if (running) begin
            if (!y[DW-1]) begin
                x <= x + y_sh;
                y <= y - x_sh;
                z <= z + atan_cur;
            end else begin
                x <= x - y_sh;
                y <= y + x_sh;
                z <= z - atan_cur;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_ITER)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/antenna_phase_extractor.sv
// Per-antenna phase extraction for one I/Q snapshot using a single shared
// vectoring CORDIC, time-multiplexed across antennas.
module antenna_phase_extractor
    import antenna_phase_extractor_pkg::*;
#(
    parameter int unsigned NUM_ANTENNAS = 4,
    parameter int unsigned IQ_WIDTH     = 16,
    parameter int unsigned PHASE_WIDTH  = 16,
    parameter int unsigned CORDIC_ITERS = 14
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          iq_valid,
    output logic                          iq_ready,
    input  logic signed [IQ_WIDTH-1:0]    i_data     [0:NUM_ANTENNAS-1],
    input  logic signed [IQ_WIDTH-1:0]    q_data     [0:NUM_ANTENNAS-1],
    output logic        [PHASE_WIDTH-1:0] phase_data [0:NUM_ANTENNAS-1],
    output logic                          phase_valid,
    output logic        [NUM_ANTENNAS-1:0] zero_mag
);

    localparam int unsigned KW = (NUM_ANTENNAS > 1) ? $clog2(NUM_ANTENNAS) : 1;
    localparam logic [KW-1:0] LAST_ANT = KW'(NUM_ANTENNAS - 1);

    ape_state_e                    state;
    logic [KW-1:0]                 k;
    logic signed [IQ_WIDTH-1:0]    snap_i     [0:NUM_ANTENNAS-1];
    logic signed [IQ_WIDTH-1:0]    snap_q     [0:NUM_ANTENNAS-1];
    logic        [PHASE_WIDTH-1:0] slot_phase [0:NUM_ANTENNAS-1];
    logic [NUM_ANTENNAS-1:0]       slot_zero;
    logic                          cv_start, cv_done, cur_zero;
    logic        [PHASE_WIDTH-1:0] cv_phase;

    always_comb begin
        cv_start = (state == S_PREROT);
        cur_zero = (snap_i[k] == '0) && (snap_q[k] == '0);
    end

    cordic_vector_iter #(
        .IQ_WIDTH    (IQ_WIDTH),
        .PHASE_WIDTH (PHASE_WIDTH),
        .CORDIC_ITERS(CORDIC_ITERS)
    ) u_cordic (
        .clk  (clk),
        .reset(reset),
        .start(cv_start),
        .i_in (snap_i[k]),
        .q_in (snap_q[k]),
        .done (cv_done),
        .phase(cv_phase)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            k           <= '0;
            iq_ready    <= 1'b1;
            phase_valid <= 1'b0;
            zero_mag    <= '0;
            for (int unsigned j = 0; j < NUM_ANTENNAS; j++)
                phase_data[j] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (iq_valid && iq_ready) begin
                        snap_i   <= i_data;
                        snap_q   <= q_data;
                        k        <= '0;
                        iq_ready <= 1'b0;
                        state    <= S_PREROT;
                    end
                end
                S_PREROT: state <= S_ITER;
                S_ITER: begin
                    if (cv_done)
                        state <= S_STORE;
                end
                S_STORE: begin
                    slot_phase[k] <= cur_zero ? '0 : cv_phase;
                    slot_zero[k]  <= cur_zero;
                    if (k == LAST_ANT) begin
                        // Last slot is forwarded directly so the outputs are
                        // already updated while the FSM sits in DONE.
                        for (int unsigned j = 0; j < NUM_ANTENNAS - 1; j++) begin
                            phase_data[j] <= slot_phase[j];
                            zero_mag[j]   <= slot_zero[j];
                        end
                        phase_data[LAST_ANT] <= cur_zero ? '0 : cv_phase;
                        zero_mag[LAST_ANT]   <= cur_zero;
                        phase_valid          <= 1'b1;
                        state                <= S_DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= S_PREROT;
                    end
                end
                S_DONE: begin
                    phase_valid <= 1'b0;
                    iq_ready    <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
